ls_dma_engine: RTL and testbench

//  DMA-side initiator for the SPU Local Store: moves quadwords between an external channel and LS.
//  GET = external->LS (LS writes); PUT = LS->external (LS reads).

---
 rtl/ls_dma_engine.sv | 161 ++++++++++++++++
 tb/tb_ls_dma_engine.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ls_dma_engine.sv
// Local Store DMA initiator: moves 1..16 quadwords between an external
// stream and the LS secondary arbiter port, one tagged command at a time.
module ls_dma_engine #(
    parameter int LS_ADDR_W = 15,
    parameter int QW_W      = 128,
    parameter int CNT_W     = 5,
    parameter int TAG_W     = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_is_put,
    input  logic [LS_ADDR_W-1:0] cmd_ls_addr,
    input  logic [CNT_W-1:0]     cmd_qw_count,
    input  logic [TAG_W-1:0]     cmd_tag,
    input  logic                 ext_in_valid,
    output logic                 ext_in_ready,
    input  logic [QW_W-1:0]      ext_in_data,
    output logic                 ext_out_valid,
    input  logic                 ext_out_ready,
    output logic [QW_W-1:0]      ext_out_data,
    output logic                 ls_req_valid,
    input  logic                 ls_req_grant,
    output logic                 ls_req_write,
    output logic [LS_ADDR_W-1:0] ls_req_addr,
    output logic [QW_W-1:0]      ls_req_wdata,
    input  logic                 ls_rd_valid,
    input  logic [QW_W-1:0]      ls_rd_data,
    output logic                 done_valid,
    output logic [TAG_W-1:0]     done_tag,
    output logic                 done_error,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE,
        GET_DATA,
        GET_WR,
        PUT_RD,
        PUT_WAIT,
        PUT_SEND,
        DONE,
        ERR_DONE
    } state_t;

    localparam logic [LS_ADDR_W-1:0] QW_BYTES = LS_ADDR_W'(16);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

    state_t               state_q, state_d;
    logic [LS_ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]     rem_q;
    logic [TAG_W-1:0]     tag_q;
    logic [QW_W-1:0]      wdata_q;
    logic [QW_W-1:0]      rdata_q;

    logic accept, cmd_bad, in_take, ls_take, rd_take, qw_done;

    // Direction is carried by the FSM path itself, so no separate flag.
    assign cmd_ready    = (state_q == IDLE) & ~reset;
    assign accept       = cmd_valid & cmd_ready;
    assign cmd_bad      = (cmd_qw_count == '0) | (cmd_ls_addr[3:0] != 4'd0);
    assign busy         = (state_q != IDLE);
    assign ls_req_addr  = addr_q;
    assign ls_req_wdata = wdata_q;
    assign ext_out_data = rdata_q;
    assign done_tag     = done_valid ? tag_q : '0;

    always_comb begin
        state_d       = state_q;
        ext_in_ready  = 1'b0;
        ext_out_valid = 1'b0;
        ls_req_valid  = 1'b0;
        ls_req_write  = 1'b0;
        done_valid    = 1'b0;
        done_error    = 1'b0;
        in_take       = 1'b0;
        ls_take       = 1'b0;
        rd_take       = 1'b0;
        qw_done       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd_bad)         state_d = ERR_DONE;
                    else if (cmd_is_put) state_d = PUT_RD;
                    else                 state_d = GET_DATA;
                end
            end
            GET_DATA: begin
                ext_in_ready = 1'b1;
                if (ext_in_valid) begin
                    in_take = 1'b1;
                    state_d = GET_WR;
                end
            end
            GET_WR: begin
                ls_req_valid = 1'b1;
                ls_req_write = 1'b1;
                if (ls_req_grant) begin
                    ls_take = 1'b1;
                    qw_done = 1'b1;
                    state_d = (rem_q == CNT_ONE) ? DONE : GET_DATA;
                end
            end
            PUT_RD: begin
                ls_req_valid = 1'b1;
                if (ls_req_grant) begin
                    ls_take = 1'b1;
                    state_d = PUT_WAIT;
                end
            end
            PUT_WAIT: begin
                if (ls_rd_valid) begin
                    rd_take = 1'b1;
                    state_d = PUT_SEND;
                end
            end
            PUT_SEND: begin
                ext_out_valid = 1'b1;
                if (ext_out_ready) begin
                    qw_done = 1'b1;
                    state_d = (rem_q == CNT_ONE) ? DONE : PUT_RD;
                end
            end
            DONE: begin
                done_valid = 1'b1;
                state_d    = IDLE;
            end
            ERR_DONE: begin
                done_valid = 1'b1;
                done_error = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            tag_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= cmd_ls_addr;
                rem_q  <= cmd_qw_count;
                tag_q  <= cmd_tag;
            end
            if (in_take) wdata_q <= ext_in_data;
            // Natural overflow of the LS_ADDR_W-bit add gives the 32KB wrap.
            if (ls_take) addr_q <= addr_q + QW_BYTES;
            if (qw_done) rem_q <= rem_q - CNT_ONE;
            if (rd_take) rdata_q <= ls_rd_data;
        end
    end

endmodule

// File: tb/tb_ls_dma_engine.sv
// Randomized directed bench for ls_dma_engine against an LS memory model
// and per-command expected address/data sequences.
module tb_ls_dma_engine;

    logic         clock = 1'b0;
    logic         reset;
    logic         cmd_valid, cmd_ready, cmd_is_put;
    logic [14:0]  cmd_ls_addr;
    logic [4:0]   cmd_qw_count, cmd_tag;
    logic         ext_in_valid, ext_in_ready;
    logic [127:0] ext_in_data;
    logic         ext_out_valid, ext_out_ready;
    logic [127:0] ext_out_data;
    logic         ls_req_valid, ls_req_grant, ls_req_write;
    logic [14:0]  ls_req_addr;
    logic [127:0] ls_req_wdata;
    logic         ls_rd_valid;
    logic [127:0] ls_rd_data;
    logic         done_valid, done_error, busy;
    logic [4:0]   done_tag;

    logic [127:0] mem [0:2047];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    ls_dma_engine dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_is_put(cmd_is_put), .cmd_ls_addr(cmd_ls_addr),
        .cmd_qw_count(cmd_qw_count), .cmd_tag(cmd_tag),
        .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
        .ext_in_data(ext_in_data),
        .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
        .ext_out_data(ext_out_data),
        .ls_req_valid(ls_req_valid), .ls_req_grant(ls_req_grant),
        .ls_req_write(ls_req_write), .ls_req_addr(ls_req_addr),
        .ls_req_wdata(ls_req_wdata),
        .ls_rd_valid(ls_rd_valid), .ls_rd_data(ls_rd_data),
        .done_valid(done_valid), .done_tag(done_tag),
        .done_error(done_error), .busy(busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int qw_addr(input int base, input int k);
        return (base + 16 * k) % 32768;
    endfunction

    task automatic idle_inputs();
        cmd_valid     = 1'b0;
        ext_in_valid  = 1'b0;
        ext_in_data   = '0;
        ext_out_ready = 1'b0;
        ls_req_grant  = 1'b0;
        ls_rd_valid   = 1'b0;
        ls_rd_data    = '0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_req"}, ls_req_valid, 1'b0);
        chk({tag, "_inrdy"}, ext_in_ready, 1'b0);
        chk({tag, "_outv"}, ext_out_valid, 1'b0);
        chk({tag, "_done"}, done_valid, 1'b0);
    endtask

    task automatic run_cmd(input bit put, input int addr, input int cnt,
                           input int tag, input int pg, input int pr,
                           input int stall, input int abort_at);
        logic [127:0] src[$];
        logic [14:0]  pa;
        logic [127:0] pw, po;
        bit err, done, pv, pov, abort, g, r;
        int k_ls, k_ext, pend, rd_addr, age_req, age_out, cyc;
        err = (cnt == 0) || (addr % 16 != 0);
        done = 0; pv = 0; pov = 0; abort = 0;
        k_ls = 0; k_ext = 0; pend = -1; rd_addr = 0;
        age_req = 0; age_out = 0; cyc = 0;
        for (int k = 0; k < cnt; k++)
            src.push_back({$urandom, $urandom, $urandom, $urandom});
        @(negedge clock);
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid    = 1'b1;
        cmd_is_put   = put;
        cmd_ls_addr  = addr[14:0];
        cmd_qw_count = cnt[4:0];
        cmd_tag      = tag[4:0];
        @(negedge clock);
        cmd_valid = 1'b0;
        if (err) begin
            chk("err_done", done_valid, 1'b1);
            chk("err_flag", done_error, 1'b1);
            chk("err_tag", done_tag, tag[4:0]);
            chk("err_req", ls_req_valid, 1'b0);
            chk("err_inrdy", ext_in_ready, 1'b0);
            chk("err_outv", ext_out_valid, 1'b0);
            @(negedge clock);
            chk("err_pulse_end", done_valid, 1'b0);
            chk("err_ready_after", cmd_ready, 1'b1);
            return;
        end
        chk("busy_run", busy, 1'b1);
        chk("cmd_ready_busy", cmd_ready, 1'b0);
        while (!done && !abort && cyc < 2000) begin
            cyc++;
            ls_req_grant  = 1'b0;
            ext_in_valid  = 1'b0;
            ext_out_ready = 1'b0;
            ls_rd_valid   = 1'b0;
            ls_rd_data    = '0;
            if (done_valid) begin
                chk("done_error", done_error, 1'b0);
                chk("done_tag", done_tag, tag[4:0]);
                chk("qw_moved", put ? k_ext : k_ls, cnt);
                if (!put && pg == 100 && pr == 100 && stall == 0)
                    chk("get_latency", cyc, 2 * cnt + 1);
                done = 1;
            end else begin
                if (pend == 0) begin
                    ls_rd_valid = 1'b1;
                    ls_rd_data  = mem[rd_addr / 16];
                    pend = -1;
                end else if (pend > 0) begin
                    pend--;
                end else if ($urandom_range(99) < 20) begin
                    ls_rd_valid = 1'b1;
                    ls_rd_data  = {$urandom, $urandom, $urandom, $urandom};
                end
                if (ls_req_valid) begin
                    if (pv) begin
                        chk("req_addr_stable", ls_req_addr, pa);
                        chk("req_wdata_stable", ls_req_wdata, pw);
                    end else begin
                        chk("req_addr", ls_req_addr, qw_addr(addr, k_ls));
                        chk("req_write", ls_req_write, !put);
                        if (!put) chk("req_wdata", ls_req_wdata, src[k_ls]);
                        else chk("one_rd_outstanding", pend, -1);
                    end
                    g = (age_req >= stall) && ($urandom_range(99) < pg);
                    ls_req_grant = g;
                    if (g) begin
                        if (!put) mem[ls_req_addr / 16] = ls_req_wdata;
                        else begin
                            pend    = $urandom_range(0, 2);
                            rd_addr = ls_req_addr;
                        end
                        k_ls++;
                        pv = 0;
                        age_req = 0;
                    end else begin
                        pv = 1; pa = ls_req_addr; pw = ls_req_wdata;
                        age_req++;
                    end
                end else pv = 0;
                if (ext_in_ready && k_ext < cnt && $urandom_range(99) < pr) begin
                    ext_in_valid = 1'b1;
                    ext_in_data  = src[k_ext];
                    k_ext++;
                end
                if (ext_out_valid) begin
                    if (pov) chk("out_data_stable", ext_out_data, po);
                    else chk("put_data", ext_out_data,
                             mem[qw_addr(addr, k_ext) / 16]);
                    r = (age_out >= stall) && ($urandom_range(99) < pr);
                    ext_out_ready = r;
                    if (r) begin
                        k_ext++;
                        pov = 0;
                        age_out = 0;
                        abort = (abort_at > 0) && (k_ext == abort_at);
                    end else begin
                        pov = 1; po = ext_out_data;
                        age_out++;
                    end
                end else pov = 0;
                if (put) chk("put_no_inrdy", ext_in_ready, 1'b0);
                else chk("get_no_outv", ext_out_valid, 1'b0);
            end
            @(posedge clock);
            if (abort) begin
                #1 reset = 1'b1;
                idle_inputs();
                #1;
                chk_quiet("rst_now");
                chk("rst_busy", busy, 1'b0);
                chk("rst_cmd_ready", cmd_ready, 1'b0);
                chk("rst_addr", ls_req_addr, 15'd0);
                chk("rst_odata", ext_out_data, 128'd0);
                @(negedge clock);
                @(negedge clock);
                chk("rst_hold_done", done_valid, 1'b0);
                reset = 1'b0;
                #1;
                chk("rst_release_ready", cmd_ready, 1'b1);
                chk_quiet("rst_after");
            end else begin
                @(negedge clock);
            end
        end
        if (abort) return;
        chk("cmd_timeout", done, 1'b1);
        idle_inputs();
        chk("done_pulse_end", done_valid, 1'b0);
        chk("ready_after_done", cmd_ready, 1'b1);
        chk("idle_after_done", busy, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++)
            mem[i] = {$urandom, $urandom, $urandom, $urandom};
        cmd_is_put   = 1'b0;
        cmd_ls_addr  = '0;
        cmd_qw_count = '0;
        cmd_tag      = '0;
        idle_inputs();
        reset = 1'b1;
        #2;
        chk("reset_cmd_ready", cmd_ready, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk_quiet("reset");
        chk("reset_wdata", ls_req_wdata, 128'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("release_cmd_ready", cmd_ready, 1'b1);

        run_cmd(0, 'h0100, 2, 3, 100, 100, 0, 0);
        run_cmd(1, 'h0200, 3, 7, 100, 100, 0, 0);
        run_cmd(0, 'h0300, 1, 9, 100, 100, 4, 0);
        run_cmd(1, 'h0400, 2, 1, 100, 100, 3, 0);
        run_cmd(0, 'h0500, 0, 11, 100, 100, 0, 0);
        run_cmd(1, 'h0104, 2, 12, 100, 100, 0, 0);
        run_cmd(0, 'h7FF0, 2, 13, 100, 100, 0, 0);
        run_cmd(1, 'h7FF0, 2, 14, 100, 100, 0, 0);
        run_cmd(0, 'h0600, 16, 15, 100, 100, 0, 0);
        run_cmd(1, 'h1000, 4, 5, 100, 100, 0, 1);
        run_cmd(0, 'h1000, 3, 6, 100, 100, 0, 0);
        run_cmd(1, 'h1000, 3, 8, 100, 100, 0, 0);

        for (int n = 0; n < 40; n++) begin
            int a;
            a = $urandom_range(0, 2047) * 16;
            if ($urandom_range(7) == 0) a += $urandom_range(1, 15);
            run_cmd($urandom_range(1), a, $urandom_range(0, 16),
                    $urandom_range(0, 31), $urandom_range(30, 100),
                    $urandom_range(30, 100), $urandom_range(0, 2), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
